// File: rtl/ddr2_cmd_decoder.sv
// DDR2 command/address bus receiver: decodes commands, tracks per-bank open state, flags protocol errors.
// Define DDR2_CMD_TIMING_CHECK_EN to build the tRCD/tRP/tRAS/tRFC counters and error codes 3,4,5,7.
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module ddr2_cmd_decoder #(
  parameter int NUM_BANK = 8,
  parameter int RANK_IDX = 0,
  parameter int T_RCD    = 4,
  parameter int T_RP     = 4,
  parameter int T_RAS    = 12,
  parameter int T_RFC    = 51
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cke,
  input  logic [`DRAM_CS_WIDTH-1:0]   cs_n,
  input  logic                        ras_n,
  input  logic                        cas_n,
  input  logic                        we_n,
  input  logic [`DRAM_BA_WIDTH-1:0]   ba,
  input  logic [`DRAM_ADDR_WIDTH-1:0] addr,
  output logic                        cmd_valid,
  output logic [3:0]                  cmd_code,
  output logic [`DRAM_BA_WIDTH-1:0]   cmd_ba,
  output logic [`DRAM_ADDR_WIDTH-1:0] cmd_addr,
  output logic                        cmd_ap,
  output logic [NUM_BANK-1:0]         bank_open,
  output logic                        err_valid,
  output logic [2:0]                  err_code
);
  localparam int BAW = `DRAM_BA_WIDTH;

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ACT  = 4'd1;
  localparam logic [3:0] C_RD   = 4'd2;
  localparam logic [3:0] C_WR   = 4'd3;
  localparam logic [3:0] C_PRE  = 4'd4;
  localparam logic [3:0] C_PREA = 4'd5;
  localparam logic [3:0] C_REF  = 4'd6;
  localparam logic [3:0] C_MRS  = 4'd7;

  logic [3:0]          dec;
  logic                is_rw;
  logic                is_mode;
  logic                ap;
  logic [NUM_BANK-1:0] open_nxt;
  logic                e_state_ref;
  logic                e_act_open;
  logic                e_rw_closed;
  logic                e_rfc;
  logic                e_rp;
  logic                e_rcd;
  logic                e_ras;
  logic [2:0]          err;
  logic                cs_unused;

  // Only the selected rank's chip select matters; the other bits are ignored.
  assign cs_unused = ^cs_n;

  always_comb begin : decode
    dec = C_NOP;
    if (cke && !cs_n[RANK_IDX]) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  dec = C_ACT;
        3'b101:  dec = C_RD;
        3'b100:  dec = C_WR;
        3'b010:  dec = addr[10] ? C_PREA : C_PRE;
        3'b001:  dec = C_REF;
        3'b000:  dec = C_MRS + {2'b00, ba[1:0]};
        default: dec = C_NOP;
      endcase
    end
  end

  assign is_rw   = (dec == C_RD) || (dec == C_WR);
  assign is_mode = (dec >= C_MRS);
  assign ap      = is_rw && addr[10];

  always_comb begin : bank_next
    open_nxt = bank_open;
    case (dec)
      C_ACT:   open_nxt[ba] = 1'b1;
      C_PRE:   open_nxt[ba] = 1'b0;
      C_PREA:  open_nxt     = '0;
      default: if (ap) open_nxt[ba] = 1'b0;
    endcase
  end

  assign e_state_ref = (dec == C_REF || is_mode) && (|bank_open);
  assign e_act_open  = (dec == C_ACT) && bank_open[ba];
  assign e_rw_closed = is_rw && !bank_open[ba];

`ifdef DDR2_CMD_TIMING_CHECK_EN
  localparam int CW = $clog2(T_RFC + T_RAS + T_RCD + T_RP + 1);
  // Counters hold the remaining wait; loading T-1 makes a command exactly T cycles later legal.
  localparam logic [CW-1:0] RCD_LD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] RP_LD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RAS_LD = CW'(T_RAS - 1);
  localparam logic [CW-1:0] RFC_LD = CW'(T_RFC - 1);

  logic [NUM_BANK-1:0] rcd_busy;
  logic [NUM_BANK-1:0] rp_busy;
  logic [NUM_BANK-1:0] ras_busy;
  logic [CW-1:0]       rfc_q;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic          hit;
    logic          rp_load;
    logic [CW-1:0] rcd_q;
    logic [CW-1:0] rp_q;
    logic [CW-1:0] ras_q;

    assign hit     = (ba == BAW'(b));
    assign rp_load = (hit && ((dec == C_PRE && bank_open[b]) || ap)) ||
                     (dec == C_PREA && bank_open[b]);
    assign rcd_busy[b] = (rcd_q != '0);
    assign rp_busy[b]  = (rp_q != '0);
    assign ras_busy[b] = (ras_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcd_q <= '0;
        rp_q  <= '0;
        ras_q <= '0;
      end else begin
        if (hit && dec == C_ACT) begin
          rcd_q <= RCD_LD;
          ras_q <= RAS_LD;
        end else begin
          if (rcd_q != '0) rcd_q <= rcd_q - CW'(1);
          if (ras_q != '0) ras_q <= ras_q - CW'(1);
        end
        if (rp_load)          rp_q <= RP_LD;
        else if (rp_q != '0)  rp_q <= rp_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : rfc_cnt
    if (!rst_n)              rfc_q <= '0;
    else if (dec == C_REF)   rfc_q <= RFC_LD;
    else if (rfc_q != '0)    rfc_q <= rfc_q - CW'(1);
  end

  assign e_rfc = (dec != C_NOP) && (rfc_q != '0);
  assign e_rp  = (dec == C_ACT) && rp_busy[ba];
  assign e_rcd = is_rw && rcd_busy[ba];
  assign e_ras = ((dec == C_PRE) && bank_open[ba] && ras_busy[ba]) ||
                 ((dec == C_PREA) && (|(bank_open & ras_busy)));
`else
  localparam int timing_unused = T_RCD + T_RP + T_RAS + T_RFC;
  assign e_rfc = 1'b0;
  assign e_rp  = 1'b0;
  assign e_rcd = 1'b0;
  assign e_ras = 1'b0;
`endif

  always_comb begin : err_prio
    err = 3'd0;
    if (e_rfc)            err = 3'd7;
    else if (e_state_ref) err = 3'd6;
    else if (e_act_open)  err = 3'd1;
    else if (e_rw_closed) err = 3'd2;
    else if (e_rp)        err = 3'd4;
    else if (e_rcd)       err = 3'd3;
    else if (e_ras)       err = 3'd5;
  end

  // bank_open is itself the bank state; on ACT cmd_addr carries the opened row.
  always_ff @(posedge clk or negedge rst_n) begin : out_reg
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 4'd0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      cmd_ap    <= 1'b0;
      bank_open <= '0;
      err_valid <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      cmd_valid <= (dec != C_NOP);
      cmd_code  <= dec;
      cmd_ba    <= ba;
      cmd_addr  <= addr;
      cmd_ap    <= ap;
      bank_open <= open_nxt;
      err_valid <= (err != 3'd0);
      err_code  <= err;
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_decoder.sv
// Scoreboard bench for ddr2_cmd_decoder: a timestamp-based protocol model predicts every cycle's outputs.
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 2
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_cmd_decoder;
  localparam int BAW   = `DRAM_BA_WIDTH;
  localparam int AW    = `DRAM_ADDR_WIDTH;
  localparam int CSW   = `DRAM_CS_WIDTH;
  localparam int NB    = 8;
  localparam int RANK  = 0;
  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 12;
  localparam int T_RFC = 51;
`ifdef DDR2_CMD_TIMING_CHECK_EN
  localparam bit TM = 1'b1;
`else
  localparam bit TM = 1'b0;
`endif

  localparam logic [2:0] R_ACT = 3'b011;
  localparam logic [2:0] R_RD  = 3'b101;
  localparam logic [2:0] R_WR  = 3'b100;
  localparam logic [2:0] R_PRE = 3'b010;
  localparam logic [2:0] R_REF = 3'b001;
  localparam logic [2:0] R_MRS = 3'b000;
  localparam logic [2:0] R_NOP = 3'b111;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cke;
  logic [CSW-1:0] cs_n;
  logic           ras_n, cas_n, we_n;
  logic [BAW-1:0] ba;
  logic [AW-1:0]  addr;
  logic           cmd_valid;
  logic [3:0]     cmd_code;
  logic [BAW-1:0] cmd_ba;
  logic [AW-1:0]  cmd_addr;
  logic           cmd_ap;
  logic [NB-1:0]  bank_open;
  logic           err_valid;
  logic [2:0]     err_code;

  ddr2_cmd_decoder #(
    .NUM_BANK(NB), .RANK_IDX(RANK), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .cmd_ap(cmd_ap), .bank_open(bank_open), .err_valid(err_valid),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    logic [3:0]     code;
    logic [BAW-1:0] ba;
    logic [AW-1:0]  addr;
    logic           ap;
    logic [NB-1:0]  open;
    logic           ev;
    logic [2:0]     ec;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            now      = 0;
  logic [NB-1:0] m_open;
  int            t_act[NB];
  int            t_pre[NB];
  int            t_ref;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, now, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open = '0;
    t_ref  = -1000;
    for (int i = 0; i < NB; i++) begin
      t_act[i] = -1000;
      t_pre[i] = -1000;
    end
  endtask

  // Protocol model: timing rules expressed as "cycles since last trigger < minimum".
  task automatic predict(input logic c_cke, input logic c_cs, input logic [2:0] rcw,
                         input logic [BAW-1:0] b, input logic [AW-1:0] a, output exp_t e);
    logic [3:0] c;
    int         err;
    bit         rw;
    bit         anyras;
    c = 4'd0;
    if (c_cke && !c_cs) begin
      case (rcw)
        R_ACT:   c = 4'd1;
        R_RD:    c = 4'd2;
        R_WR:    c = 4'd3;
        R_PRE:   c = a[10] ? 4'd5 : 4'd4;
        R_REF:   c = 4'd6;
        R_MRS:   c = 4'(7 + b[1:0]);
        default: c = 4'd0;
      endcase
    end
    rw = (c == 4'd2) || (c == 4'd3);
    anyras = 1'b0;
    for (int i = 0; i < NB; i++)
      if (m_open[i] && (now - t_act[i] < T_RAS)) anyras = 1'b1;
    err = 0;
    if (TM && c != 0 && (now - t_ref < T_RFC))                        err = 7;
    else if ((c == 6 || c >= 7) && m_open != '0)                      err = 6;
    else if (c == 1 && m_open[b])                                      err = 1;
    else if (rw && !m_open[b])                                         err = 2;
    else if (TM && c == 1 && (now - t_pre[b] < T_RP))                  err = 4;
    else if (TM && rw && (now - t_act[b] < T_RCD))                     err = 3;
    else if (TM && ((c == 4 && m_open[b] && (now - t_act[b] < T_RAS)) ||
                    (c == 5 && anyras)))                               err = 5;
    case (c)
      4'd1: begin m_open[b] = 1'b1; t_act[b] = now; end
      4'd4: if (m_open[b]) begin m_open[b] = 1'b0; t_pre[b] = now; end
      4'd5: begin
        for (int i = 0; i < NB; i++) if (m_open[i]) t_pre[i] = now;
        m_open = '0;
      end
      4'd6: t_ref = now;
      default: if (rw && a[10]) begin m_open[b] = 1'b0; t_pre[b] = now; end
    endcase
    e.valid = (c != 4'd0);
    e.code  = c;
    e.ba    = b;
    e.addr  = a;
    e.ap    = rw && a[10];
    e.open  = m_open;
    e.ev    = (err != 0);
    e.ec    = 3'(err);
  endtask

  task automatic compare_pending();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("cmd_valid", cmd_valid, e.valid);
    if (e.valid) begin
      check("cmd_code", cmd_code, e.code);
      check("cmd_ba", cmd_ba, e.ba);
      check("cmd_addr", cmd_addr, e.addr);
      check("cmd_ap", cmd_ap, e.ap);
    end
    check("bank_open", bank_open, e.open);
    check("err_valid", err_valid, e.ev);
    if (e.ev) check("err_code", err_code, e.ec);
  endtask

  task automatic step(input logic c_cke, input logic c_cs, input logic [2:0] rcw,
                      input int b, input int a);
    exp_t e;
    @(negedge clk);
    compare_pending();
    cke = c_cke;
    cs_n = '1;
    cs_n[RANK] = c_cs;
    {ras_n, cas_n, we_n} = rcw;
    ba = BAW'(b);
    addr = AW'(a);
    predict(c_cke, c_cs, rcw, BAW'(b), AW'(a), e);
    sb.push_back(e);
    now++;
  endtask

  task automatic nops(input int n);
    repeat (n) step(1'b1, 1'b0, R_NOP, 0, 0);
  endtask
  task automatic act(input int b, input int row); step(1'b1, 1'b0, R_ACT, b, row); endtask
  task automatic rd(input int b, input bit ap);  step(1'b1, 1'b0, R_RD, b, ap ? 'h423 : 'h023); endtask
  task automatic wr(input int b, input bit ap);  step(1'b1, 1'b0, R_WR, b, ap ? 'h438 : 'h038); endtask
  task automatic pre(input int b);               step(1'b1, 1'b0, R_PRE, b, 'h000); endtask
  task automatic prea();                         step(1'b1, 1'b0, R_PRE, 0, 'h400); endtask
  task automatic refr();                         step(1'b1, 1'b0, R_REF, 0, 0); endtask
  task automatic mrs(input int b, input int v);  step(1'b1, 1'b0, R_MRS, b, v); endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_cmd_code"}, cmd_code, 4'd0);
    check({tag, "_cmd_addr"}, cmd_addr, '0);
    check({tag, "_bank_open"}, bank_open, '0);
    check({tag, "_err_valid"}, err_valid, 1'b0);
    check({tag, "_err_code"}, err_code, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", now);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cke = 1'b1;
    cs_n = '1;
    {ras_n, cas_n, we_n} = R_NOP;
    ba = '0;
    addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    nops(10);
    act(2, 'h1A5); nops(3); rd(2, 1'b0);          // exactly tRCD later: legal
    act(1, 'h0F0); nops(1); rd(1, 1'b0);          // tRCD violation
    act(7, 'h011); nops(2); wr(7, 1'b0);          // one cycle short of tRCD
    wr(5, 1'b0);                                  // write to closed bank
    act(0, 'h100); act(0, 'h101);                 // ACT to open bank
    act(3, 'h033);
    act(6, 'h066); nops(1); pre(6);               // tRAS violation
    act(6, 'h067);                                // tRP violation
    nops(12);
    prea();
    refr();                                       // all closed: legal
    act(4, 'h044);                                // tRFC violation
    nops(52);
    mrs(0, 'h0432);                               // mode write with a bank open
    pre(4);
    mrs(1, 'h0004); mrs(2, 'h0000); mrs(3, 'h0001);
    act(2, 'h1A5); refr();                        // REF with a bank open
    nops(52);
    rd(2, 1'b1);                                  // auto-precharge closes bank 2
    nops(1); act(2, 'h1A6);                       // tRP after auto-precharge
    pre(7);                                       // PRE to closed bank: legal
    step(1'b0, 1'b0, R_ACT, 3, 'h010);            // cke low: ignored
    step(1'b1, 1'b1, R_ACT, 3, 'h010);            // deselected: NOP
    act(5, 'h077);

    @(posedge clk);
    #1;
    compare_pending();
    rst_n = 1'b0;
    cs_n = '1;
    {ras_n, cas_n, we_n} = R_NOP;
    #1;
    check_zero("midrst");
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    nops(3);
    act(5, 'h078);
    nops(2);
    @(negedge clk);
    compare_pending();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
